// File: rtl/siaminer_pkg.sv
// Shared definitions for the nonce dispatcher: default widths and the
// dispatcher job-state enumeration, imported by every rtl/ file.
package siaminer_pkg;

    // Default nonce width in bits.
    localparam int NONCE_W_DEF = 64;

    // Default log2 depth of the in-flight nonce FIFO (8 entries).
    localparam int FIFO_AW_DEF = 3;

    // Job-level state of the dispatcher.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO holding nonces that are issued but have no result yet.
// Ports: clk_i, rst_ni (sync, active-low), push_i/data_i, pop_i,
//        head_o (combinational head), full_o, empty_o.
module nonce_fifo
    import siaminer_pkg::*;
#(
    parameter int AW = FIFO_AW_DEF,
    parameter int DW = NONCE_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/nonce_dispatch.sv
// Hands consecutive nonces to a hash core, tracks them until their results
// return in order, and captures the first winning nonce of the job.
// Ports: clk, rst (sync, active-low); job control start/nonce_base/
//        nonce_count/abort; hash offer hash_valid/hash_ready/hash_nonce;
//        results res_done/res_found; status busy/finished/win_valid/
//        win_nonce/err.
module nonce_dispatch
    import siaminer_pkg::*;
#(
    parameter int FIFO_AW = FIFO_AW_DEF,
    parameter int NONCE_W = NONCE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [31:0]        nonce_count,
    input  logic               abort,
    output logic               hash_valid,
    input  logic               hash_ready,
    output logic [NONCE_W-1:0] hash_nonce,
    input  logic               res_done,
    input  logic               res_found,
    output logic               busy,
    output logic               finished,
    output logic               win_valid,
    output logic [NONCE_W-1:0] win_nonce,
    output logic               err
);

    disp_state_e state_q;
    disp_state_e state_d;

    logic [NONCE_W-1:0] next_q;
    logic [NONCE_W-1:0] next_d;
    logic [31:0]        rem_q;
    logic [31:0]        rem_d;
    logic               win_valid_q;
    logic               win_valid_d;
    logic [NONCE_W-1:0] win_nonce_q;
    logic [NONCE_W-1:0] win_nonce_d;
    logic               err_q;
    logic               err_d;
    // Remembers an abort so a pending offer can finish before stopping.
    logic               stop_q;
    logic               stop_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [NONCE_W-1:0] fifo_head;

    logic start_acc;
    logic hs;
    logic pop;
    logic capture;
    logic stop_req;

    assign start_acc = start & (state_q == ST_IDLE);

    // Offer depends only on registered state, so it cannot glitch or
    // change while waiting for hash_ready.
    assign hash_valid = (state_q == ST_ISSUE) & (rem_q != 32'd0) & ~fifo_full;
    assign hash_nonce = next_q;
    assign hs         = hash_valid & hash_ready;

    // Pop only against the registered empty flag, so a nonce pushed in the
    // same cycle is never mistaken for the head.
    assign pop     = res_done & ~fifo_empty;
    assign capture = pop & res_found & ~win_valid_q;

    assign stop_req = abort | stop_q | win_valid_q;

    assign busy      = (state_q == ST_ISSUE) | (state_q == ST_DRAIN);
    assign finished  = (state_q == ST_DONE);
    assign win_valid = win_valid_q;
    assign win_nonce = win_nonce_q;
    assign err       = err_q;

    nonce_fifo #(
        .AW (FIFO_AW),
        .DW (NONCE_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (hs),
        .data_i  (next_q),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Datapath next-state.
    always_comb begin
        next_d      = next_q;
        rem_d       = rem_q;
        win_valid_d = win_valid_q;
        win_nonce_d = win_nonce_q;
        err_d       = err_q;
        stop_d      = stop_q;
        if (start_acc) begin
            next_d      = nonce_base;
            rem_d       = nonce_count;
            win_valid_d = 1'b0;
            win_nonce_d = '0;
            err_d       = 1'b0;
            stop_d      = 1'b0;
        end else begin
            if (hs) begin
                next_d = next_q + NONCE_W'(1);
                rem_d  = rem_q - 32'd1;
            end
            if (capture) begin
                win_valid_d = 1'b1;
                win_nonce_d = fifo_head;
            end
            if (res_done & fifo_empty) begin
                err_d = 1'b1;
            end
            if (abort & busy) begin
                stop_d = 1'b1;
            end
        end
    end

    // Job FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (nonce_count == 32'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((rem_d == 32'd0) || (stop_req && (!hash_valid || hs))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            next_q      <= '0;
            rem_q       <= '0;
            win_valid_q <= 1'b0;
            win_nonce_q <= '0;
            err_q       <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            rem_q       <= rem_d;
            win_valid_q <= win_valid_d;
            win_nonce_q <= win_nonce_d;
            err_q       <= err_d;
            stop_q      <= stop_d;
        end
    end

endmodule

// File: tb/tb_nonce_dispatch.sv
// Testbench for nonce_dispatch: emulated hash core, queue-based job model
// checked every cycle, plus directed literal expectations.
module tb_nonce_dispatch;

    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] nonce_base;
    logic [31:0]   nonce_count;
    logic          abort;
    logic          hash_valid;
    logic          hash_ready;
    logic [NW-1:0] hash_nonce;
    logic          res_done = 1'b0;
    logic          res_found = 1'b0;
    logic          busy;
    logic          finished;
    logic          win_valid;
    logic [NW-1:0] win_nonce;
    logic          err;

    always #5 clk = ~clk;

    nonce_dispatch #(
        .FIFO_AW (3),
        .NONCE_W (NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .nonce_base  (nonce_base),
        .nonce_count (nonce_count),
        .abort       (abort),
        .hash_valid  (hash_valid),
        .hash_ready  (hash_ready),
        .hash_nonce  (hash_nonce),
        .res_done    (res_done),
        .res_found   (res_found),
        .busy        (busy),
        .finished    (finished),
        .win_valid   (win_valid),
        .win_nonce   (win_nonce),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- emulated hash core ----------------
    int            cyc = 0;
    int            core_lat = 3;
    bit            core_hold = 0;
    bit            find_en = 0;
    logic [NW-1:0] find_nonce = '0;
    bit            extra_done = 0;
    logic [NW-1:0] core_q[$];
    int            due_q[$];
    logic [NW-1:0] issued[$];
    int            issued_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            core_q.delete();
            due_q.delete();
        end else if (hash_valid && hash_ready) begin
            core_q.push_back(hash_nonce);
            due_q.push_back(cyc + core_lat - 1);
            issued.push_back(hash_nonce);
            issued_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        #2;
        res_done  = extra_done;
        res_found = 1'b0;
        if (!extra_done && !core_hold && core_q.size() > 0 && due_q[0] <= cyc) begin
            res_done  = 1'b1;
            res_found = find_en && (core_q[0] == find_nonce);
            void'(core_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    // ---------------- behavioural model ----------------
    // m_ph: 0 idle, 1 issuing, 2 draining, 3 done
    int            m_ph = 0;
    logic [NW-1:0] m_next = '0;
    logic [31:0]   m_rem = '0;
    bit            m_win = 0;
    logic [NW-1:0] m_winn = '0;
    bit            m_err = 0;
    bit            m_stop = 0;
    logic [NW-1:0] m_fifo[$];

    function automatic bit m_valid();
        return (m_ph == 1) && (m_rem != 0) && (m_fifo.size() < 8);
    endfunction

    always @(posedge clk) begin
        bit            offer;
        bit            take;
        bit            winb;
        int            sz0;
        logic [NW-1:0] head;
        if (!rst) begin
            m_ph = 0; m_next = '0; m_rem = '0; m_win = 0;
            m_winn = '0; m_err = 0; m_stop = 0;
            m_fifo.delete();
        end else begin
            offer = m_valid();
            take  = offer && hash_ready;
            winb  = m_win;
            sz0   = m_fifo.size();
            if (res_done && sz0 == 0) m_err = 1;
            if (res_done && sz0 != 0) begin
                head = m_fifo.pop_front();
                if (res_found && !m_win) begin
                    m_win  = 1;
                    m_winn = head;
                end
            end
            if (abort && (m_ph == 1 || m_ph == 2)) m_stop = 1;
            case (m_ph)
                0: if (start) begin
                    m_next = nonce_base; m_rem = nonce_count;
                    m_win = 0; m_winn = '0; m_err = 0; m_stop = 0;
                    m_ph = (nonce_count == 0) ? 3 : 1;
                end
                1: begin
                    if (take) begin
                        m_fifo.push_back(m_next);
                        m_next = m_next + 1;
                        m_rem  = m_rem - 1;
                    end
                    if (m_rem == 0 || ((abort || m_stop || winb) && (!offer || take)))
                        m_ph = 2;
                end
                2: if (sz0 == 0) m_ph = 3;
                default: m_ph = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("hash_valid", hash_valid, m_valid());
        if (m_valid()) check("hash_nonce", hash_nonce, m_next);
        check("busy", busy, (m_ph == 1 || m_ph == 2));
        check("finished", finished, (m_ph == 3));
        check("win_valid", win_valid, m_win);
        check("win_nonce", win_nonce, m_winn);
        check("err", err, m_err);
        if (finished) fin_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_job(input logic [NW-1:0] b, input logic [31:0] c);
        tick();
        start = 1'b1; nonce_base = b; nonce_count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int f0, input int limit);
        int n;
        n = 0;
        while (fin_cnt == f0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (fin_cnt == f0) begin
            errors++;
            $display("FAIL wait_finished timeout after %0d cycles", limit);
        end
    endtask

    initial begin
        int f0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; hash_ready = 1'b1;
        nonce_base = '0; nonce_count = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", hash_valid, 0);
        check("rst_fin", finished, 0);
        check("rst_winv", win_valid, 0);
        check("rst_winn", win_nonce, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // back-to-back issue, no winner
        issued.delete(); issued_cyc.delete(); f0 = fin_cnt;
        run_job(64'h10, 4);
        check("t1_first_valid", hash_valid, 1);
        check("t1_first_nonce", hash_nonce, 64'h10);
        wait_done(f0, 100);
        check("t1_n", issued.size(), 4);
        for (int i = 0; i < 4 && i < issued.size(); i++)
            check("t1_nonce", issued[i], 64'h10 + i);
        if (issued_cyc.size() == 4)
            check("t1_b2b", issued_cyc[3] - issued_cyc[0], 3);
        check("t1_winv", win_valid, 0);
        tick();
        check("t1_fin_once", fin_cnt - f0, 1);

        // nonce wraparound
        issued.delete(); f0 = fin_cnt;
        run_job(64'hFFFF_FFFF_FFFF_FFFE, 4);
        wait_done(f0, 100);
        check("t3_n", issued.size(), 4);
        if (issued.size() == 4) begin
            check("t3_0", issued[0], 64'hFFFF_FFFF_FFFF_FFFE);
            check("t3_1", issued[1], 64'hFFFF_FFFF_FFFF_FFFF);
            check("t3_2", issued[2], 64'h0);
            check("t3_3", issued[3], 64'h1);
        end

        // winner found mid-job
        issued.delete(); f0 = fin_cnt;
        find_en = 1; find_nonce = 64'h105;
        run_job(64'h100, 20);
        wait_done(f0, 200);
        check("t2_winv", win_valid, 1);
        check("t2_winn", win_nonce, 64'h105);
        check("t2_stopped", issued.size() < 20, 1);
        check("t2_past_win", issued.size() > 6, 1);
        tick();
        check("t2_fin_once", fin_cnt - f0, 1);
        find_en = 0;

        // results withheld: FIFO fills at 8
        issued.delete(); f0 = fin_cnt;
        core_hold = 1;
        run_job(64'h200, 12);
        repeat (20) tick();
        check("t4_full_n", issued.size(), 8);
        check("t4_full_valid", hash_valid, 0);
        core_hold = 0;
        wait_done(f0, 200);
        check("t4_n", issued.size(), 12);
        if (issued.size() == 12) check("t4_resume", issued[8], 64'h208);

        // zero-length job, then stray result
        issued.delete(); f0 = fin_cnt;
        run_job(64'h300, 0);
        check("t5_fin", finished, 1);
        check("t5_valid", hash_valid, 0);
        tick();
        check("t5_fin_off", finished, 0);
        check("t5_none", issued.size(), 0);
        extra_done = 1;
        tick();
        extra_done = 0;
        check("t5_err", err, 1);
        tick();

        // abort while offer stalled
        issued.delete(); f0 = fin_cnt;
        hash_ready = 1'b0;
        run_job(64'h500, 10);
        check("t6_valid", hash_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_hold1", hash_nonce, 64'h500);
        check("t6_v1", hash_valid, 1);
        tick();
        check("t6_hold2", hash_nonce, 64'h500);
        hash_ready = 1'b1;
        wait_done(f0, 100);
        check("t6_n", issued.size(), 1);
        if (issued.size() == 1) check("t6_nonce", issued[0], 64'h500);

        // reset mid-job
        f0 = fin_cnt;
        core_hold = 1;
        run_job(64'h700, 5);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        core_hold = 0;
        repeat (6) tick();
        check("t7_nofin", fin_cnt - f0, 0);
        check("t7_busy", busy, 0);
        check("t7_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
